// File: rtl/niu32_io_pkg.sv
// Shared I/O page definitions for the Niu32 board I/O responder.
package niu32_io_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned SW_W   = 10;
    localparam int unsigned HEX_W  = 16;
    localparam int unsigned LEDR_W = 10;
    localparam int unsigned LEDG_W = 8;

    // I/O page register map; CPU decode and assembler header use the same values
    localparam logic [ADDR_W-1:0] ADDR_HEX     = 32'hFFFF_0000;
    localparam logic [ADDR_W-1:0] ADDR_LEDR    = 32'hFFFF_0020;
    localparam logic [ADDR_W-1:0] ADDR_LEDG    = 32'hFFFF_0040;
    localparam logic [ADDR_W-1:0] ADDR_KEY     = 32'hFFFF_0100;
    localparam logic [ADDR_W-1:0] ADDR_KEYEDGE = 32'hFFFF_0104;
    localparam logic [ADDR_W-1:0] ADDR_SWITCH  = 32'hFFFF_0120;

    localparam int unsigned DEBOUNCE_DEFAULT = 50000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } io_state_e;

    // True when the address falls in the board I/O page
    function automatic logic is_io_page(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:16] == 16'hFFFF;
    endfunction

endpackage

// File: rtl/niu32_key_debounce.sv
// Key input conditioning: 2-flop sync, tick-sampled debounce, sticky press flags.
module niu32_key_debounce
    import niu32_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_n,
    input  logic             edge_clr,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_edge
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0] sync1_q, sync2_q;
    logic [KEY_W-1:0] samp_q, samp_d;
    logic [KEY_W-1:0] deb_q, deb_d;
    logic [KEY_W-1:0] edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_c;

    // Debounce sampling and edge capture; a new press beats a same-cycle clear
    always_comb begin
        tick_c = (cnt_q == CNT_LAST);
        cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
        samp_d = samp_q;
        deb_d  = deb_q;
        if (tick_c) begin
            if (sync2_q == samp_q) begin
                deb_d = sync2_q;
            end
            samp_d = sync2_q;
        end
        edge_d = (edge_clr ? '0 : edge_q) | (deb_d & ~deb_q);
    end

    // Synchronizer, tick counter and debounce state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            deb_q   <= '0;
            edge_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
            samp_q  <= samp_d;
            deb_q   <= deb_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_state = deb_q;
    assign key_edge  = edge_q;

endmodule

// File: rtl/niu32_io_responder.sv
// Memory-mapped I/O responder for the Niu32 board I/O page.
module niu32_io_responder
    import niu32_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              io_hit,
    input  logic [KEY_W-1:0]  key_n,
    input  logic [SW_W-1:0]   switch_in,
    output logic [HEX_W-1:0]  hex_value,
    output logic [LEDR_W-1:0] ledr,
    output logic [LEDG_W-1:0] ledg
);

    io_state_e         state_q, state_d;
    logic [HEX_W-1:0]  hex_q, hex_d;
    logic [LEDR_W-1:0] ledr_q, ledr_d;
    logic [LEDG_W-1:0] ledg_q, ledg_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [SW_W-1:0]   sw_sync1_q, sw_sync2_q;
    logic [KEY_W-1:0]  key_state, key_edge;
    logic              edge_clr_c;
    logic              unused_wdata_c;

    assign unused_wdata_c = ^wdata[DATA_W-1:HEX_W];

    niu32_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk       (clk),
        .reset     (reset),
        .key_n     (key_n),
        .edge_clr  (edge_clr_c),
        .key_state (key_state),
        .key_edge  (key_edge)
    );

    // Switch synchronizer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= switch_in;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one access per request, then wait for req to drop
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_RESP;
            ST_RESP: state_d = ST_HOLD;
            ST_HOLD: if (!req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: decode and perform the access in IDLE
    always_comb begin
        hex_d      = hex_q;
        ledr_d     = ledr_q;
        ledg_d     = ledg_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        edge_clr_c = 1'b0;
        if (state_q == ST_IDLE && req) begin
            ack_d = 1'b1;
            if (we) begin
                case (addr)
                    ADDR_HEX:  hex_d  = wdata[HEX_W-1:0];
                    ADDR_LEDR: ledr_d = wdata[LEDR_W-1:0];
                    ADDR_LEDG: ledg_d = wdata[LEDG_W-1:0];
                    default:   err_d  = 1'b1;
                endcase
            end else begin
                case (addr)
                    ADDR_HEX:     rdata_d = DATA_W'(hex_q);
                    ADDR_LEDR:    rdata_d = DATA_W'(ledr_q);
                    ADDR_LEDG:    rdata_d = DATA_W'(ledg_q);
                    ADDR_KEY:     rdata_d = DATA_W'(key_state);
                    ADDR_SWITCH:  rdata_d = DATA_W'(sw_sync2_q);
                    ADDR_KEYEDGE: begin
                        rdata_d    = DATA_W'(key_edge);
                        edge_clr_c = 1'b1;
                    end
                    default: begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                endcase
            end
        end
    end

    // Output and register-file state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q   <= '0;
            ledr_q  <= '0;
            ledg_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            hex_q   <= hex_d;
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign io_hit    = is_io_page(addr);
    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign hex_value = hex_q;
    assign ledr      = ledr_q;
    assign ledg      = ledg_q;

endmodule

// File: doc/niu32_io_responder.md
Name: niu32_io_responder

Overview:
Memory-mapped I/O responder for the Niu32 multicycle CPU: the device end of the CPU's load/store path for the board I/O page (0xFFFF_xxxx). Decodes requests, owns the HEX/LEDR/LEDG output registers, and synchronizes, debounces and edge-captures KEY and SWITCH inputs. Answers each request with a registered one-cycle ack. Sits beside data memory; the CPU routes to it when io_hit is high.

Parameters:
ADDR_HEX, 32'hFFFF0000, HEX value register (low 16 bits drive four digits)
ADDR_LEDR, 32'hFFFF0020, red LED register
ADDR_LEDG, 32'hFFFF0040, green LED register
ADDR_KEY, 32'hFFFF0100, debounced key state (read-only)
ADDR_KEYEDGE, 32'hFFFF0104, sticky key-press flags (read-to-clear)
ADDR_SWITCH, 32'hFFFF0120, synchronized switch state (read-only)
DEBOUNCE_CYCLES, 50000, clk cycles between debounce samples; must be >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
req  in  1  access request; held by CPU until ack seen
we  in  1  1 = store, 0 = load; valid with req
addr  in  32  byte address; valid with req
wdata  in  32  store data; valid with req
rdata  out  32  load data; valid while ack = 1
ack  out  1  one-cycle completion pulse
err  out  1  valid with ack; access to unmapped or read-only location
io_hit  out  1  combinational: addr[31:16] == 16'hFFFF
key_n  in  4  board keys, active-low, asynchronous
switch_in  in  10  board switches, asynchronous
hex_value  out  16  to four SevenSeg instances
ledr  out  10  red LEDs
ledg  out  8  green LEDs

Behaviour:
- Reset (async): hex_value, ledr, ledg, rdata = 0; ack = err = 0; FSM IDLE; synchronizers, debounced keys, key edges, sample history, tick counter = 0.
- Input sync: 2-flop synchronizers on ~key_n (pressed = 1) and switch_in.
- Debounce: tick counter 0..DEBOUNCE_CYCLES-1, tick on wrap. At tick: if synced key equals previous tick's sample, debounced <= sample; sample history <= synced key.
- Edge capture: debounced bit 0->1 sets its key_edge bit. Clear-on-read and a new set on the same cycle: set wins.
- FSM IDLE: on req = 1, decode latched addr, perform access on that edge, ack <= 1, go RESP. req = 0: stay, ack = 0.
- FSM RESP: ack <= 0, go HOLD. Exactly one ack per request.
- FSM HOLD: wait for req = 0, then IDLE. A req held high never produces a second access.
- Latency: req sampled at edge N -> ack/rdata/err high for the cycle after edge N.
- Stores: HEX <= wdata[15:0]; LEDR <= wdata[9:0]; LEDG <= wdata[7:0]; err = 0. Store to KEY, KEYEDGE, SWITCH or an unmapped address: no state change, err = 1.
- Loads: zero-extended register value: HEX/LEDR/LEDG current contents, KEY {28'b0,debounced}, SWITCH {22'b0,sync}, KEYEDGE {28'b0,edge}. Reading KEYEDGE clears all edge bits on the same edge. Unmapped: rdata = 0, err = 1.
- Address match: full 32-bit compare; no aliasing; low two bits must match exactly.
- rdata holds its last value outside ack; consumers sample it only during ack.
- Reset mid-transaction: FSM returns to IDLE and ack drops immediately. The CPU must reissue; a store is either fully applied or not applied.

Decomposition:
- Shared package niu32_io_pkg: the I/O address constants (also used by the CPU decode and the assembler header), FSM state encoding (IDLE, RESP, HOLD), DEBOUNCE default.
- One natural sub-module: niu32_key_debounce (synchronizer + tick-sampled debounce + edge capture for a 4-bit key vector), instantiated once.

Test Plan:
- Reset: assert reset mid-run -> hex_value = 0, ledr = 0, ledg = 0, ack = 0, err = 0. A read of ADDR_KEYEDGE after release returns 0.
- Store HEX: addr 0xFFFF0000, wdata 0x1234ABCD -> hex_value = 0xABCD, ack one cycle after req, err = 0. A subsequent load returns 0x0000ABCD.
- Store LEDR 0xFFFFFFFF, LEDG 0x5A -> ledr = 0x3FF, ledg = 0x5A. A load of LEDR returns 0x000003FF.
- Key bounce, with DEBOUNCE_CYCLES = 4: key_n[2] toggles for 3 cycles, then holds 0 -> KEY reads 0x4 within 2 ticks + 2 sync cycles. First KEYEDGE read returns 0x4, second returns 0x0.
- Errors: store to 0xFFFF0120 -> ack with err = 1, switch read unchanged. Load from 0xFFFF0008 -> rdata = 0, err = 1.
- Handshake: req held high 10 cycles with we = 1 -> exactly one ack pulse, one register update. Reset asserted in the RESP cycle -> ack drops the same cycle, FSM IDLE.
